// File: rtl/trigger_sequencer_if.sv
// Command/status bundle between control logic and trigger_sequencer.
// Optional TRIGGER_SEQUENCER_TOGGLE_EN adds the latched i_mode select.
interface trigger_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic [CNT_W-1:0] i_delay;
    logic [CNT_W-1:0] i_high;
    logic [CNT_W-1:0] i_low;
    logic [NUM_W-1:0] i_count;
`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
    logic             i_mode;
`endif
    logic             o_posedge;
    logic             o_negedge;
    logic             o_edge;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_stop, i_delay, i_high, i_low, i_count,
`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
        output i_mode,
`endif
        input  o_posedge, o_negedge, o_edge, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_delay, i_high, i_low, i_count,
`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
        input  i_mode,
`endif
        output o_posedge, o_negedge, o_edge, o_busy, o_done
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Pulse-train sequencer issuing registered set/clear (or toggle) strobes to a trigger generator.
// Define TRIGGER_SEQUENCER_TOGGLE_EN to add i_mode and route strobes to o_edge.
module trigger_sequencer #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    trigger_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic [NUM_W-1:0] r_count;
    logic [NUM_W-1:0] r_pulses;
    logic             r_stop_pend;
    logic             r_pos;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NUM_W-1:0] w_pulses_nxt;
    logic             w_pend_nxt;
    logic             w_pos_nxt;
    logic             w_neg_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_load;
    logic             w_expire;
    logic             w_last;
    logic [NUM_W-1:0] w_pulses_inc;
    logic [NUM_W-1:0] w_pulses_sat;
    logic [CNT_W-1:0] w_high_in;
    logic [CNT_W-1:0] w_low_in;

    // Zero high/low times behave as one cycle so every phase lasts at least a cycle.
    assign w_high_in    = (bus.i_high == '0) ? CNT_W'(1) : bus.i_high;
    assign w_low_in     = (bus.i_low  == '0) ? CNT_W'(1) : bus.i_low;
    assign w_expire     = (r_cnt == CNT_W'(1));
    assign w_pulses_inc = r_pulses + 1'b1;
    assign w_pulses_sat = (r_pulses == '1) ? r_pulses : w_pulses_inc;
    assign w_last       = (r_count != '0) && (w_pulses_inc == r_count);

    // A stop that lands on a strobe edge is deferred one cycle via r_stop_pend;
    // the deferred stop then overrides any further schedule.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pulses_nxt = r_pulses;
        w_pend_nxt   = 1'b0;
        w_pos_nxt    = 1'b0;
        w_neg_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start && !bus.i_stop && !r_busy) begin
                    w_load       = 1'b1;
                    w_pulses_nxt = '0;
                    if (bus.i_delay == '0) begin
                        w_state_nxt = S_HIGH;
                        w_pos_nxt   = 1'b1;
                        w_cnt_nxt   = w_high_in;
                    end else begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = bus.i_delay;
                    end
                end
            end
            S_DELAY: begin
                if (w_expire) begin
                    w_state_nxt = S_HIGH;
                    w_pos_nxt   = 1'b1;
                    w_cnt_nxt   = r_high;
                    w_pend_nxt  = bus.i_stop;
                end else if (bus.i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_HIGH: begin
                if (r_stop_pend) begin
                    w_state_nxt = S_IDLE;
                    w_neg_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else if (w_expire) begin
                    w_neg_nxt    = 1'b1;
                    w_pulses_nxt = w_pulses_sat;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = r_low;
                        w_pend_nxt  = bus.i_stop;
                    end
                end else if (bus.i_stop) begin
                    // Abort from HIGH always leaves the generator low.
                    w_state_nxt = S_IDLE;
                    w_neg_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_LOW: begin
                if (r_stop_pend) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = S_HIGH;
                    w_pos_nxt   = 1'b1;
                    w_cnt_nxt   = r_high;
                    w_pend_nxt  = bus.i_stop;
                end else if (bus.i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Busy covers the done cycle, so a start arriving with done is still ignored.
    assign w_busy_nxt = (w_state_nxt != S_IDLE) || w_done_nxt;

`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
    logic r_mode;
    logic r_edge;
    logic w_mode;

    assign w_mode = w_load ? bus.i_mode : r_mode;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mode <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            if (w_load) begin
                r_mode <= bus.i_mode;
            end
            r_edge <= (w_pos_nxt | w_neg_nxt) & w_mode;
        end
    end

    assign bus.o_edge = r_edge;
`else
    logic w_mode;

    assign w_mode     = 1'b0;
    assign bus.o_edge = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_high      <= '0;
            r_low       <= '0;
            r_count     <= '0;
            r_pulses    <= '0;
            r_stop_pend <= 1'b0;
            r_pos       <= 1'b0;
            r_neg       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pulses    <= w_pulses_nxt;
            r_stop_pend <= w_pend_nxt;
            if (w_load) begin
                r_high  <= w_high_in;
                r_low   <= w_low_in;
                r_count <= bus.i_count;
            end
            r_pos  <= w_pos_nxt & ~w_mode;
            r_neg  <= w_neg_nxt & ~w_mode;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.o_posedge = r_pos;
    assign bus.o_negedge = r_neg;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized self-checking bench for trigger_sequencer against an arithmetic schedule model.
// Works with and without TRIGGER_SEQUENCER_TOGGLE_EN.
module tb_trigger_sequencer;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;
    localparam int NEVER = 1 << 30;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    trigger_sequencer_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

    trigger_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int seq_id   = 0;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got{pos,neg,edge,busy,done}=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.o_posedge, bus.o_negedge, bus.o_edge, bus.o_busy, bus.o_done};
    endfunction

    // Strobe at relative cycle t: {posedge, negedge}. Pulse k rises at 1+d+k*per, falls hh later.
    function automatic logic [1:0] strobe_at(int t, int d, int hh, int per, int cnt);
        int u, k, r;
        if (t < 1 + d) return 2'b00;
        u = t - 1 - d;
        k = u / per;
        r = u % per;
        if (cnt != 0 && k >= cnt) return 2'b00;
        return {r == 0, r == hh};
    endfunction

    function automatic bit in_high(int t, int d, int hh, int per);
        if (t < 1 + d) return 1'b0;
        return ((t - 1 - d) % per) < hh;
    endfunction

    // Expected outputs at relative cycle t for a sequence started at t=0, stop pulse at s (0 = none).
    function automatic logic [4:0] model(int t, int d, int h, int l, int cnt, int s, bit mode);
        int  hh, ll, per, e, se, fin;
        bit  stopped, pos, neg;
        logic [1:0] sk;
        hh  = (h == 0) ? 1 : h;
        ll  = (l == 0) ? 1 : l;
        per = hh + ll;
        e   = (cnt != 0) ? (1 + d + (cnt - 1) * per + hh) : NEVER;
        se  = s;
        stopped = 1'b0;
        if (s > 0) begin
            if (strobe_at(s + 1, d, hh, per, cnt) != 2'b00) se = s + 1;
            stopped = (se < e);
        end
        fin = stopped ? se + 1 : e;
        if (t < 1 || t > fin) return 5'b0;
        if (stopped && t > se) begin
            pos = 1'b0;
            neg = (t == se + 1) && in_high(se, d, hh, per);
        end else begin
            sk  = strobe_at(t, d, hh, per, cnt);
            pos = sk[1];
            neg = sk[0];
        end
        if (mode) return {1'b0, 1'b0, pos | neg, 1'b1, t == fin};
        return {pos, neg, 1'b0, 1'b1, t == fin};
    endfunction

    function automatic int seq_end(int d, int h, int l, int cnt, int s);
        int t;
        t = 1;
        while (model(t, d, h, l, cnt, s, 1'b0) != 5'b0 && t < 100000) t++;
        return t - 1;
    endfunction

    task automatic drive(input bit start, input bit stop, input int d, input int h,
                         input int l, input int cnt, input bit mode);
        bus.i_start = start;
        bus.i_stop  = stop;
        bus.i_delay = CNT_W'(d);
        bus.i_high  = CNT_W'(h);
        bus.i_low   = CNT_W'(l);
        bus.i_count = NUM_W'(cnt);
`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
        bus.i_mode  = mode;
`else
        if (mode) $display("note: mode ignored in this build");
`endif
    endtask

    task automatic drive_noise(input bit start, input bit stop);
        drive(start, stop, $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    endtask

    // One full sequence: idle check at t=0 with start, then every cycle through the idle cycle after done.
    task automatic run_seq(input int d, input int h, input int l, input int cnt,
                           input bit mode, input int s, input bit noise);
        int fin;
        seq_id++;
        fin = seq_end(d, h, l, cnt, s);
        @(negedge i_clk);
        check($sformatf("seq%0d_t0", seq_id), outs(), 5'b0);
        drive(1'b1, 1'b0, d, h, l, cnt, mode);
        for (int t = 1; t <= fin + 1; t++) begin
            @(negedge i_clk);
            check($sformatf("seq%0d_t%0d", seq_id, t), outs(), model(t, d, h, l, cnt, s, mode));
            if (noise && t <= fin) drive_noise(1'($urandom_range(0, 1)), t == s);
            else drive(1'b0, t == s, d, h, l, cnt, mode);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

`ifdef TRIGGER_SEQUENCER_TOGGLE_EN
    localparam bit HAS_TOGGLE = 1'b1;
`else
    localparam bit HAS_TOGGLE = 1'b0;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d, h, l, cnt, s, e;
        bit mode;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

        repeat (3) begin
            @(negedge i_clk);
            check("in_reset", outs(), 5'b0);
        end
        i_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check($sformatf("idle%0d", i), outs(), 5'b0);
            drive(1'b0, i[0], 0, 0, 0, 0, 1'b0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

        run_seq(3, 2, 4, 3, 1'b0, 0, 1'b0);
        run_seq(0, 0, 0, 2, 1'b0, 0, 1'b0);
        run_seq(8, 5, 5, 0, 1'b0, 20, 1'b0);
        run_seq(3, 2, 4, 3, 1'b0, 3, 1'b0);
        run_seq(3, 2, 4, 3, 1'b0, 5, 1'b0);
        run_seq(3, 2, 4, 3, 1'b0, 17, 1'b0);
        run_seq(6, 2, 2, 1, 1'b0, 2, 1'b0);
        run_seq(1, 3, 3, 0, 1'b0, 12, 1'b0);

        // Start together with stop is ignored.
        @(negedge i_clk);
        drive(1'b1, 1'b1, 2, 2, 2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check($sformatf("start_stop%0d", i), outs(), 5'b0);
            drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        end

        // Asynchronous reset in the middle of HIGH: outputs drop at once, no negedge afterwards.
        @(negedge i_clk);
        drive(1'b1, 1'b0, 2, 6, 2, 2, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            @(negedge i_clk);
            check($sformatf("pre_rst_t%0d", t), outs(), model(t, 2, 6, 2, 2, 0, 1'b0));
            drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        end
        i_rst = 1'b0;
        #1;
        check("rst_async", outs(), 5'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check($sformatf("rst_hold%0d", i), outs(), 5'b0);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_release", outs(), 5'b0);

        run_seq(3, 2, 4, 3, 1'b0, 0, 1'b1);

        if (HAS_TOGGLE) begin
            run_seq(3, 2, 4, 3, 1'b1, 0, 1'b0);
            run_seq(8, 5, 5, 0, 1'b1, 20, 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            d    = $urandom_range(0, 5);
            h    = $urandom_range(0, 4);
            l    = $urandom_range(0, 4);
            cnt  = $urandom_range(0, 4);
            mode = HAS_TOGGLE ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cnt == 0) begin
                s = $urandom_range(1, 40);
            end else begin
                e = seq_end(d, h, l, cnt, 0);
                s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e + 2) : 0;
            end
            run_seq(d, h, l, cnt, mode, s, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Programmable pulse-train controller that drives the set/clear/toggle command inputs of a trigger generator.
- Latches delay, high time, low time and pulse count on start. Issues single-cycle posedge/negedge (or edge) command strobes at exact cycle offsets.
- Sits between the control/CSR logic and one trigger generator instance. Reports busy/done back to the control logic.

Parameters:
CNT_W, 16, width of delay/high/low cycle counters
NUM_W, 8, width of pulse-count field; value 0 means continuous

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
i_start  input  1  start request, sampled per cycle; accepted only in IDLE
i_stop  input  1  abort request, sampled per cycle
i_delay  input  CNT_W  cycles from start acceptance to first posedge strobe
i_high  input  CNT_W  cycles from posedge strobe to negedge strobe (0 treated as 1)
i_low  input  CNT_W  cycles from negedge strobe to next posedge strobe (0 treated as 1)
i_count  input  NUM_W  number of pulses; 0 = run until i_stop
o_posedge  output  1  set strobe to generator, 1-cycle pulse
o_negedge  output  1  clear strobe to generator, 1-cycle pulse
o_edge  output  1  toggle strobe to generator, 1-cycle pulse (see Optional Feature)
o_busy  output  1  high while a sequence is active
o_done  output  1  1-cycle pulse on sequence completion or abort

Behaviour:
- Reset: i_rst low immediately forces IDLE, clears all counters and latched fields. All outputs are 0. Asynchronous, valid mid-sequence; no strobe is emitted on reset.
- All outputs are registered; strobes never last more than 1 cycle.
- States: IDLE, DELAY, HIGH, LOW.
- IDLE: if i_start=1 and i_stop=0 in cycle T, latch i_delay/i_high/i_low/i_count and go to DELAY; o_busy=1 from T+1. Inputs are ignored after latching. i_start with i_stop in the same cycle is ignored.
- DELAY: first o_posedge is asserted in cycle T+1+D (D=latched delay; D=0 gives posedge at T+1). The strobe cycle is the first cycle of HIGH.
- HIGH: o_negedge is asserted exactly H cycles after the o_posedge cycle (H=max(high,1)), then enter LOW. The pulse counter increments on each negedge.
- LOW:
  - If count!=0 and pulses==count, o_done=1 in the same cycle as the final o_negedge, and the next state is IDLE (o_busy=0 from the following cycle). No trailing low period.
  - Otherwise the next o_posedge is asserted L cycles after the o_negedge (L=max(low,1)), re-entering HIGH.
- Continuous (count=0): the pulse counter saturates at all-ones and never terminates the sequence.
- i_stop in DELAY or LOW: the next state is IDLE, o_done=1 next cycle, no strobe.
- i_stop in HIGH: o_negedge=1 and o_done=1 next cycle (the generator is always left low), then IDLE.
- i_stop in IDLE: no effect. i_start while busy: ignored.
- Boundary: a scheduled strobe and i_stop in the same cycle → the scheduled strobe wins; stop takes effect the next cycle.
- Counters are CNT_W bits and down-count from the latched value; no wrap-around is possible.

Optional Feature:
- Macro TRIGGER_SEQUENCER_TOGGLE_EN.
- Defined: adds input i_mode (1 bit, latched on start). With i_mode=1, every strobe that would be o_posedge or o_negedge is issued on o_edge instead, at identical timing. o_posedge/o_negedge stay 0. i_stop during HIGH issues o_edge. With i_mode=0, behaviour is as above.
- Undefined: i_mode is absent and o_edge is constant 0.

Test Plan:
1. Reset release, idle 10 cycles → all outputs 0, no strobes.
2. delay=3, high=2, low=4, count=3, start at cycle 0 → posedge at 4, 10, 16; negedge at 6, 12, 18; done at 18; busy 1..18.
3. delay=0, high=0, low=0, count=2 → posedge at 1, 3; negedge at 2, 4; done at 4.
4. count=0, high=5, low=5; stop during HIGH at cycle 20 → negedge+done at 21, busy=0 at 22, no further strobes.
5. Reset low mid-HIGH → outputs 0 same cycle, no negedge. New start after release works with fresh fields. Start while busy is ignored (timing unchanged).
6. With TRIGGER_SEQUENCER_TOGGLE_EN, i_mode=1, scenario 2 → o_edge at 4, 6, 10, 12, 16, 18; o_posedge/o_negedge never asserted.
